control_sequencer: RTL and testbench

Self-timed microcode sequencer for the RV32 core. It replaces the externally stepped decoder: it owns its own step counter and a memory request/ready handshake with wait states. It also adds illegal-opcode and memory-timeout traps, a resumable halt state, and a retired-instruction counter. It sits between the instruction register/ALU flags and every datapath enable (PC, IR, MAR, register file, immediate unit, ALU, sign-extender, memory bus).

---
 rtl/cpu_ctrl_pkg.sv | 65 ++++++
 rtl/branch_cond.sv | 25 ++
 rtl/control_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the RV32 control sequencer: datapath enable bundle, sequencer
// states, major-opcode codes, trap causes and memory access sizes.
package cpu_ctrl_pkg;

    typedef struct packed {
        logic       pc_oe;
        logic       pc_we;
        logic       pc_inc;
        logic       pc_oe2;
        logic       ir_we;
        logic       mar_we;
        logic       mar_oe;
        logic       rs1_en;
        logic       rs2_en;
        logic       rd_we;
        logic       mem_rw;
        logic       se_en;
        logic       se_oe;
        logic       imm_ena;
        logic       imm_enb;
        logic       imm_enc;
        logic       f3_ov;
        logic [3:0] f3_val;
        logic       mdb_en;
        logic       alu_oe;
        logic [1:0] mem_size;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_EXEC1,
        ST_EXEC2,
        ST_HALT,
        ST_TRAP
    } state_t;

    // Decoded instruction class, one per distinct sequencing behaviour.
    typedef enum logic [3:0] {
        IC_ALU, IC_ALUI, IC_LUI, IC_AUIPC, IC_JAL0, IC_JAL, IC_JALR,
        IC_BRANCH, IC_LOAD, IC_STORE, IC_HALT, IC_ILL
    } iclass_t;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_ALU    = 5'b01100;
    localparam logic [4:0] OP_ALUI   = 5'b00100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd1;

    localparam logic [1:0] MS_BYTE = 2'd1;
    localparam logic [1:0] MS_HALF = 2'd2;
    localparam logic [1:0] MS_WORD = 2'd3;

    localparam logic [3:0] F3_ADD = 4'b0000;
    localparam logic [3:0] F3_CMP = 4'b1000;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from funct3 and the ALU compare flags.
module branch_cond (
    input  logic [2:0] funct3,
    input  logic       carry,
    input  logic       zero,
    input  logic       lt,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = carry;
            3'b111:  taken = ~carry;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Self-timed microcode sequencer: FETCH/EXEC1/EXEC2 stepping with memory wait
// states, illegal-opcode and memory-timeout traps, resumable halt, retire counter.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int INSTRET_W   = 32,
    parameter int TRAP_EN     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [4:0]           rd,
    input  logic                 carry,
    input  logic                 zero,
    input  logic                 lt,
    input  logic                 mem_ready,
    input  logic                 resume,
    input  logic                 trap_ack,
    output logic [CTRL_W-1:0]    ctrl,
    output logic                 mem_req,
    output logic [1:0]           step,
    output logic                 branch_taken,
    output logic                 halted,
    output logic                 trap_valid,
    output logic [1:0]           trap_cause,
    output logic [INSTRET_W-1:0] instret
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);

    ctrl_t                c;
    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic [1:0]           cause_q, cause_d;
    logic                 mreq, retire, timeout, btaken;
    logic                 br_taken, br_illegal;
    iclass_t              ic;

    function automatic iclass_t decode(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [4:0] rd_i, input logic br_ill);
        if (op == 7'd0 && f3 == 3'd0 && rd_i == 5'd0) return IC_HALT;
        if (op[1:0] != 2'b11) return IC_ILL;
        case (op[6:2])
            OP_ALU:    return IC_ALU;
            OP_ALUI:   return IC_ALUI;
            OP_LUI:    return IC_LUI;
            OP_AUIPC:  return IC_AUIPC;
            OP_JAL:    return (rd_i == 5'd0) ? IC_JAL0 : IC_JAL;
            OP_JALR:   return (f3 == 3'd0) ? IC_JALR : IC_ILL;
            OP_BRANCH: return br_ill ? IC_ILL : IC_BRANCH;
            OP_LOAD:   return (f3 == 3'b011 || f3[2:1] == 2'b11) ? IC_ILL : IC_LOAD;
            OP_STORE:  return (f3[2] || f3[1:0] == 2'b11) ? IC_ILL : IC_STORE;
            default:   return IC_ILL;
        endcase
    endfunction

    branch_cond u_branch_cond (
        .funct3  (funct3),
        .carry   (carry),
        .zero    (zero),
        .lt      (lt),
        .taken   (br_taken),
        .illegal (br_illegal)
    );

    assign ic = decode(opcode, funct3, rd, br_illegal);

    always_comb begin
        c       = '0;
        state_d = state_q;
        cause_d = cause_q;
        mreq    = 1'b0;
        retire  = 1'b0;
        btaken  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mreq       = 1'b1;
                c.pc_oe2   = 1'b1;
                c.mem_size = MS_WORD;
                if (mem_ready) begin
                    c.ir_we  = 1'b1;
                    c.pc_inc = 1'b1;
                    state_d  = ST_EXEC1;
                end
            end
            ST_EXEC1: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
                case (ic)
                    IC_ALU:   begin c.rs1_en = 1'b1; c.rs2_en = 1'b1; c.alu_oe = 1'b1; c.rd_we = 1'b1; end
                    IC_ALUI:  begin c.rs1_en = 1'b1; c.imm_ena = 1'b1; c.alu_oe = 1'b1; c.rd_we = 1'b1; end
                    IC_LUI:   begin c.imm_enc = 1'b1; c.rd_we = 1'b1; end
                    IC_AUIPC: begin c.pc_oe = 1'b1; c.imm_enc = 1'b1; c.alu_oe = 1'b1; c.rd_we = 1'b1; end
                    IC_JAL0:  begin c.pc_oe = 1'b1; c.imm_enb = 1'b1; c.alu_oe = 1'b1; c.pc_we = 1'b1; end
                    IC_JAL:   begin
                        c.pc_oe2 = 1'b1; c.rd_we = 1'b1;
                        retire = 1'b0; state_d = ST_EXEC2;
                    end
                    IC_JALR:  begin
                        // Target parks in MAR so the link write can use the PC port next step.
                        c.rs1_en = 1'b1; c.imm_ena = 1'b1; c.alu_oe = 1'b1; c.mar_we = 1'b1;
                        retire = 1'b0; state_d = ST_EXEC2;
                    end
                    IC_BRANCH: begin
                        c.rs1_en = 1'b1; c.rs2_en = 1'b1; c.f3_ov = 1'b1; c.f3_val = F3_CMP;
                        btaken = br_taken;
                        if (br_taken) begin retire = 1'b0; state_d = ST_EXEC2; end
                    end
                    IC_LOAD, IC_STORE: begin
                        c.rs1_en = 1'b1; c.imm_enb = 1'b1; c.f3_ov = 1'b1; c.f3_val = F3_ADD;
                        c.alu_oe = 1'b1; c.mar_we = 1'b1;
                        retire = 1'b0; state_d = ST_EXEC2;
                    end
                    IC_HALT: begin retire = 1'b0; state_d = ST_HALT; end
                    IC_ILL: begin
                        if (TRAP_EN != 0) begin
                            retire = 1'b0; state_d = ST_TRAP; cause_d = CAUSE_ILLEGAL;
                        end
                    end
                    default: ;
                endcase
            end
            ST_EXEC2: begin
                case (ic)
                    IC_LOAD, IC_STORE: begin
                        mreq       = 1'b1;
                        c.mar_oe   = 1'b1;
                        c.mdb_en   = 1'b1;
                        c.mem_size = funct3[1:0] + 2'd1;
                        if (ic == IC_STORE) begin
                            c.mem_rw = 1'b1; c.rs2_en = 1'b1;
                        end else begin
                            c.se_en = ~funct3[2]; c.se_oe = 1'b1; c.rd_we = mem_ready;
                        end
                        if (mem_ready) begin retire = 1'b1; state_d = ST_FETCH; end
                    end
                    IC_JALR: begin
                        c.mar_oe = 1'b1; c.pc_we = 1'b1; c.pc_oe2 = 1'b1; c.rd_we = 1'b1;
                        retire = 1'b1; state_d = ST_FETCH;
                    end
                    default: begin
                        c.pc_oe = 1'b1; c.imm_enb = 1'b1; c.f3_ov = 1'b1; c.f3_val = F3_ADD;
                        c.alu_oe = 1'b1; c.pc_we = 1'b1;
                        retire = 1'b1; state_d = ST_FETCH;
                    end
                endcase
            end
            ST_HALT: if (resume)   state_d = ST_FETCH;
            ST_TRAP: if (trap_ack) state_d = ST_FETCH;
            default: state_d = ST_FETCH;
        endcase

        // A ready in the final wait cycle completes the access rather than trapping.
        timeout = (MEM_TIMEOUT != 0) && mreq && !mem_ready && (wait_q == WAIT_LAST);
        if (timeout) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_TIMEOUT;
        end
        wait_d    = (mreq && !mem_ready && !timeout) ? wait_q + WAIT_W'(1) : '0;
        instret_d = instret_q + INSTRET_W'(retire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            wait_q    <= '0;
            instret_q <= '0;
            cause_q   <= CAUSE_ILLEGAL;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            cause_q   <= cause_d;
        end
    end

    assign ctrl         = rst ? {CTRL_W{1'b0}} : c;
    assign mem_req      = mreq & ~rst;
    assign branch_taken = btaken & ~rst;
    assign step         = (state_q == ST_EXEC1) ? 2'd1 : (state_q == ST_EXEC2) ? 2'd2 : 2'd0;
    assign halted       = (state_q == ST_HALT);
    assign trap_valid   = (state_q == ST_TRAP);
    assign trap_cause   = cause_q;
    assign instret      = instret_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: instruction-level reference model checked every
// cycle, plus directed programs with hand-computed cycle counts and counter values.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    localparam int MT = 16;
    localparam int K_SHORT = 0, K_LD = 1, K_ST = 2, K_JUMP = 3, K_BR = 4, K_HALT = 5, K_ILL = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rd = '0;
    logic        carry = 1'b0, zero = 1'b0, lt = 1'b0;
    logic        mem_ready = 1'b0, resume = 1'b0, trap_ack = 1'b0;

    logic [CTRL_W-1:0] dut_ctrl, n_ctrl;
    logic        mem_req, branch_taken, halted, trap_valid;
    logic        n_mem_req, n_branch_taken, n_halted, n_trap_valid;
    logic [1:0]  step, trap_cause, n_step, n_trap_cause;
    logic [31:0] instret, n_instret;
    ctrl_t       cv;
    assign cv = dut_ctrl;

    control_sequencer #(.MEM_TIMEOUT(MT), .INSTRET_W(32), .TRAP_EN(1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .rd(rd),
        .carry(carry), .zero(zero), .lt(lt), .mem_ready(mem_ready),
        .resume(resume), .trap_ack(trap_ack), .ctrl(dut_ctrl), .mem_req(mem_req),
        .step(step), .branch_taken(branch_taken), .halted(halted),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .instret(instret)
    );

    control_sequencer #(.MEM_TIMEOUT(MT), .INSTRET_W(32), .TRAP_EN(0)) u_nt (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .rd(rd),
        .carry(carry), .zero(zero), .lt(lt), .mem_ready(mem_ready),
        .resume(resume), .trap_ack(trap_ack), .ctrl(n_ctrl), .mem_req(n_mem_req),
        .step(n_step), .branch_taken(n_branch_taken), .halted(n_halted),
        .trap_valid(n_trap_valid), .trap_cause(n_trap_cause), .instret(n_instret)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int klass(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r);
        if (op == 7'd0 && f3 == 3'd0 && r == 5'd0) return K_HALT;
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return K_SHORT;
            7'b1101111: return (r == 5'd0) ? K_SHORT : K_JUMP;
            7'b1100111: return (f3 == 3'd0) ? K_JUMP : K_ILL;
            7'b1100011: return (f3 == 3'd2 || f3 == 3'd3) ? K_ILL : K_BR;
            7'b0000011: return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? K_ILL : K_LD;
            7'b0100011: return (f3 <= 3'd2) ? K_ST : K_ILL;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic logic bcond(input logic [2:0] f3, input logic c, input logic z, input logic l);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return l;
            3'd5: return !l;
            3'd6: return c;
            default: return !c;
        endcase
    endfunction

    int          m_st = 0;     // 0 fetch, 1 exec1, 2 exec2, 3 halt, 4 trap
    int          m_wait = 0;
    int          m_cause = 0;
    logic [31:0] m_instret = '0;

    function automatic logic m_req();
        int k;
        k = klass(opcode, funct3, rd);
        return (m_st == 0) || (m_st == 2 && (k == K_LD || k == K_ST));
    endfunction

    always @(posedge clk) begin
        int k;
        logic req, tmo;
        k = klass(opcode, funct3, rd);
        if (rst) begin
            m_st = 0; m_wait = 0; m_instret = '0; m_cause = 0;
        end else begin
            req = m_req();
            tmo = req && !mem_ready && (m_wait + 1 == MT);
            m_wait = (req && !mem_ready && !tmo) ? m_wait + 1 : 0;
            case (m_st)
                0: if (mem_ready) m_st = 1;
                1: begin
                    if (k == K_HALT) m_st = 3;
                    else if (k == K_ILL) begin m_st = 4; m_cause = 0; end
                    else if (k == K_SHORT || (k == K_BR && !bcond(funct3, carry, zero, lt))) begin
                        m_st = 0; m_instret++;
                    end else m_st = 2;
                end
                2: if (!(k == K_LD || k == K_ST) || mem_ready) begin m_st = 0; m_instret++; end
                3: if (resume) m_st = 0;
                4: if (trap_ack) m_st = 0;
                default: m_st = 0;
            endcase
            if (tmo) begin m_st = 4; m_cause = 1; end
        end
    end

    always @(negedge clk) if (chk_on) begin
        int k;
        ctrl_t ex;
        k = klass(opcode, funct3, rd);
        chk("step", step, (m_st <= 2) ? m_st : 0);
        chk("halted", halted, m_st == 3);
        chk("trap_valid", trap_valid, m_st == 4);
        chk("trap_cause", trap_cause, m_cause);
        chk("instret", instret, m_instret);
        chk("mem_req", mem_req, !rst && m_req());
        if (rst || m_st >= 3) chk("ctrl_zero", dut_ctrl, '0);
        else if (m_st == 0) begin
            ex = '0; ex.pc_oe2 = 1'b1; ex.mem_size = 2'd3;
            ex.ir_we = mem_ready; ex.pc_inc = mem_ready;
            chk("fetch_ctrl", dut_ctrl, ex);
        end else if (m_st == 1 && k == K_BR) begin
            chk("br_taken", branch_taken, bcond(funct3, carry, zero, lt));
            chk("br_e1_pc_we", cv.pc_we, 1'b0);
        end else if (m_st == 2 && (k == K_LD || k == K_ST)) begin
            chk("mem_size", cv.mem_size, funct3[1:0] + 2'd1);
            chk("mem_rw", cv.mem_rw, k == K_ST);
            chk("se_en", cv.se_en, k == K_LD && !funct3[2]);
        end else if (m_st == 2) chk("e2_pc_we", cv.pc_we, 1'b1);
    end

    // ---------------- stimulus ----------------
    int  wait_n = 0, age = 0;
    bit  hold = 1'b0;

    // One clock; memory answers each request after wait_n low cycles.
    task automatic cyc();
        logic hs;
        hs = mem_ready && mem_req;
        @(posedge clk); #2;
        if (hs) age = 0;
        if (!mem_req) begin mem_ready = 1'b0; age = 0; end
        else if (hold) mem_ready = 1'b0;
        else if (age >= wait_n) mem_ready = 1'b1;
        else begin mem_ready = 1'b0; age++; end
    endtask

    task automatic set_wait(input int n);
        wait_n = n; age = 0;
        if (mem_req && n > 0) begin mem_ready = 1'b0; age = 1; end
    endtask

    task automatic exec(input string nm, input logic [6:0] op, input logic [2:0] f3,
                        input logic [4:0] r, input int want);
        logic [31:0] i0;
        int n;
        opcode = op; funct3 = f3; rd = r; i0 = instret; n = 0;
        do begin cyc(); n++; end while (instret == i0 && !halted && !trap_valid && n < 60);
        chk(nm, n, want);
    endtask

    task automatic ack();
        trap_ack = 1'b1; cyc(); trap_ack = 1'b0;
        chk("ack_step", step, 2'd0);
        chk("ack_tv", trap_valid, 1'b0);
    endtask

    initial begin
        cyc(); chk_on = 1'b1;
        cyc(); cyc();
        chk("rst_instret", instret, 32'd0);
        chk("rst_ctrl", dut_ctrl, '0);
        chk("rst_mreq", mem_req, 1'b0);
        rst = 1'b0;
        cyc();

        exec("add_cyc",   7'b0110011, 3'd0, 5'd1, 2);
        exec("sw_cyc",    7'b0100011, 3'd2, 5'd0, 3);
        chk("instret_2", instret, 32'd2);
        zero = 1'b1;
        exec("beq_t_cyc", 7'b1100011, 3'd0, 5'd0, 3);
        zero = 1'b0;
        exec("beq_n_cyc", 7'b1100011, 3'd0, 5'd0, 2);
        carry = 1'b1;
        exec("bltu_cyc",  7'b1100011, 3'd6, 5'd0, 3);
        carry = 1'b0; lt = 1'b1;
        exec("bge_cyc",   7'b1100011, 3'd5, 5'd0, 2);
        lt = 1'b0;
        exec("jal0_cyc",  7'b1101111, 3'd0, 5'd0, 2);
        exec("jal_cyc",   7'b1101111, 3'd0, 5'd5, 3);
        exec("jalr_cyc",  7'b1100111, 3'd0, 5'd1, 3);
        exec("lui_cyc",   7'b0110111, 3'd0, 5'd2, 2);
        exec("lbu_cyc",   7'b0000011, 3'd4, 5'd3, 3);
        set_wait(2);
        exec("lw_w2_cyc", 7'b0000011, 3'd2, 5'd3, 7);
        set_wait(5);
        exec("fetch_w5",  7'b0110011, 3'd0, 5'd1, 7);
        set_wait(15);
        exec("fetch_w15", 7'b0110011, 3'd0, 5'd1, 17);
        chk("instret_14", instret, 32'd14);

        set_wait(100);
        exec("tmo_cyc",   7'b0110011, 3'd0, 5'd1, 16);
        chk("tmo_tv", trap_valid, 1'b1);
        chk("tmo_cause", trap_cause, 2'd1);
        resume = 1'b1; cyc(); cyc(); resume = 1'b0;
        chk("tmo_resume_ign", trap_valid, 1'b1);
        set_wait(0);
        ack();

        exec("ld111_cyc", 7'b0000011, 3'd7, 5'd1, 2);
        chk("ld111_cause", trap_cause, 2'd0);
        ack();
        exec("op7f_cyc",  7'b1111111, 3'd0, 5'd1, 2);
        chk("op7f_tv", trap_valid, 1'b1);
        chk("op7f_cause", trap_cause, 2'd0);
        ack();
        exec("b010_cyc",  7'b1100011, 3'd2, 5'd0, 2);
        chk("b010_tv", trap_valid, 1'b1);
        ack();
        chk("ill_instret", instret, 32'd14);

        exec("halt_cyc",  7'd0, 3'd0, 5'd0, 2);
        chk("halt_h", halted, 1'b1);
        trap_ack = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        trap_ack = 1'b0;
        chk("halt_hold", halted, 1'b1);
        resume = 1'b1; cyc(); resume = 1'b0;
        chk("resume_step", step, 2'd0);
        chk("resume_h", halted, 1'b0);
        chk("resume_instret", instret, 32'd14);

        // reset while a load is stalled in EXEC2
        opcode = 7'b0000011; funct3 = 3'd2; rd = 5'd4;
        cyc(); hold = 1'b1; mem_ready = 1'b0;
        cyc(); cyc(); cyc();
        chk("stall_step", step, 2'd2);
        rst = 1'b1; cyc();
        chk("mid_rst_step", step, 2'd0);
        chk("mid_rst_ctrl", dut_ctrl, '0);
        chk("mid_rst_instret", instret, 32'd0);
        chk("mid_rst_mreq", mem_req, 1'b0);

        hold = 1'b0; opcode = 7'b1111111; funct3 = 3'd0; rd = 5'd1;
        rst = 1'b0;
        cyc(); cyc();
        chk("nt_mid_instret", n_instret, 32'd0);
        cyc();
        chk("nt_instret", n_instret, 32'd1);
        chk("nt_step", n_step, 2'd0);
        chk("nt_tv", n_trap_valid, 1'b0);
        chk("te_tv", trap_valid, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
